// File: rtl/sweep_monitor.sv
// sweep_monitor: watches the one-hot LED bar of a rotating-bit stage, tracks the
// lit position, counts completed sweeps in BCD and latches a sticky fault after
// ERR_LIMIT consecutive bad samples.
//
// Ports:
//   clk_05    - clock, rising edge active
//   rst       - asynchronous active-low reset
//   led_in    - LED bar, led_in[i]=1 means position i is lit
//   clr_n     - synchronous active-low clear of tracking state, counters and fault
//   pos       - tracked position index 0..N-1
//   pos_valid - pos holds a valid tracked position
//   sweep_bcd - completed sweeps, BCD tens [7:4] / ones [3:0]
//   hex1/hex0 - active-low 7-segment codes of the tens / ones digit
//   err       - sticky fault flag
module sweep_monitor #(
  parameter int unsigned N         = 10,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic         clk_05,
  input  logic         rst,
  input  logic [0:N-1] led_in,
  input  logic         clr_n,
  output logic [3:0]   pos,
  output logic         pos_valid,
  output logic [7:0]   sweep_bcd,
  output logic [6:0]   hex1,
  output logic [6:0]   hex0,
  output logic         err
);

  localparam int unsigned   PW       = 4;
  localparam int unsigned   BW       = $clog2(ERR_LIMIT + 1);
  localparam logic [PW-1:0] LAST_POS = PW'(N - 1);
  localparam logic [BW-1:0] BAD_MAX  = BW'(ERR_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e        state_q;
  logic [0:N-1]  sample_q;
  logic [PW-1:0] pos_q;
  logic          valid_q;
  logic [7:0]    bcd_q;
  logic [BW-1:0] bad_q;
  logic          err_q;

  logic          smp_any;
  logic          smp_multi;
  logic          smp_onehot;
  logic [PW-1:0] smp_idx;
  logic          step_ok;
  logic          sweep_wrap;
  logic [BW-1:0] bad_d;
  logic [7:0]    bcd_d;

  // Classify the registered sample: any bit set, more than one set, last set index.
  always_comb begin
    smp_any   = 1'b0;
    smp_multi = 1'b0;
    smp_idx   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (sample_q[i]) begin
        smp_multi = smp_multi | smp_any;
        smp_any   = 1'b1;
        smp_idx   = PW'(i);
      end
    end
  end

  assign smp_onehot = smp_any & ~smp_multi;
  // Wrap is tested before step so N=16 cannot alias pos+1 onto index 0.
  assign sweep_wrap = smp_onehot && (smp_idx == '0) && (pos_q == LAST_POS);
  assign step_ok    = smp_onehot && ((smp_idx == pos_q) || (smp_idx == pos_q + PW'(1)));

  // Saturating bad-sample counter increment.
  assign bad_d = (bad_q == BAD_MAX) ? bad_q : bad_q + BW'(1);

  // BCD increment, 99 rolls over to 00.
  always_comb begin
    bcd_d = bcd_q;
    if (bcd_q[3:0] == 4'd9) begin
      bcd_d[3:0] = 4'd0;
      bcd_d[7:4] = (bcd_q[7:4] == 4'd9) ? 4'd0 : bcd_q[7:4] + 4'd1;
    end else begin
      bcd_d[3:0] = bcd_q[3:0] + 4'd1;
    end
  end

  // Sample register and tracking FSM.
  always_ff @(posedge clk_05 or negedge rst) begin
    if (!rst) begin
      sample_q <= '0;
      state_q  <= IDLE;
      pos_q    <= '0;
      valid_q  <= 1'b0;
      bcd_q    <= '0;
      bad_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      sample_q <= led_in;
      if (!clr_n) begin
        state_q <= IDLE;
        pos_q   <= '0;
        valid_q <= 1'b0;
        bcd_q   <= '0;
        bad_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (smp_onehot && (smp_idx == '0)) begin
              state_q <= TRACK;
              pos_q   <= '0;
              valid_q <= 1'b1;
            end else begin
              valid_q <= 1'b0;
            end
          end
          TRACK: begin
            if (!smp_any) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              bad_q   <= '0;
            end else if (sweep_wrap) begin
              pos_q <= '0;
              bcd_q <= bcd_d;
              bad_q <= '0;
            end else if (step_ok) begin
              pos_q <= smp_idx;
              bad_q <= '0;
            end else begin
              bad_q <= bad_d;
              if (bad_d == BAD_MAX) begin
                state_q <= FAULT;
                err_q   <= 1'b1;
                valid_q <= 1'b0;
              end
            end
          end
          FAULT: begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Active-low 7-segment encoding, segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign pos       = pos_q;
  assign pos_valid = valid_q;
  assign sweep_bcd = bcd_q;
  assign err       = err_q;
  assign hex0      = seg7(bcd_q[3:0]);
  assign hex1      = seg7(bcd_q[7:4]);

endmodule

// File: tb/tb_sweep_monitor.sv
// Testbench for sweep_monitor: directed scenarios plus randomized LED patterns,
// every output compared each cycle against a rule-level reference model.
module tb_sweep_monitor;

  localparam int N   = 10;
  localparam int LIM = 3;

  logic         clk_05 = 1'b0;
  logic         rst;
  logic         clr_n;
  logic [0:N-1] led_in;
  logic [3:0]   pos;
  logic         pos_valid;
  logic [7:0]   sweep_bcd;
  logic [6:0]   hex1;
  logic [6:0]   hex0;
  logic         err;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: mode 0=idle 1=track 2=fault, sweeps as a plain integer.
  int           m_st;
  int           m_pos;
  int           m_sw;
  int           m_bad;
  bit           m_val;
  bit           m_err;
  logic [0:N-1] m_samp;
  int           last_idx;
  bit           seen99;

  sweep_monitor #(.N(N), .ERR_LIMIT(LIM)) dut (
    .clk_05   (clk_05),
    .rst      (rst),
    .led_in   (led_in),
    .clr_n    (clr_n),
    .pos      (pos),
    .pos_valid(pos_valid),
    .sweep_bcd(sweep_bcd),
    .hex1     (hex1),
    .hex0     (hex0),
    .err      (err)
  );

  always #5 clk_05 = ~clk_05;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [0:N-1] oh(input int i);
    logic [0:N-1] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_st = 0; m_pos = 0; m_sw = 0; m_bad = 0; m_val = 1'b0; m_err = 1'b0;
    m_samp = '0;
  endtask

  // Apply one clock edge's worth of rules to the previously sampled bar.
  task automatic model_edge(input logic cl);
    int ones;
    int idx;
    ones = $countones(m_samp);
    idx  = -1;
    for (int i = 0; i < N; i++) if (m_samp[i]) idx = i;
    if (!cl) begin
      m_st = 0; m_pos = 0; m_sw = 0; m_bad = 0; m_val = 1'b0; m_err = 1'b0;
    end else if (m_st == 0) begin
      if (ones == 1 && idx == 0) begin
        m_st = 1; m_pos = 0; m_val = 1'b1;
      end else begin
        m_val = 1'b0;
      end
    end else if (m_st == 1) begin
      if (ones == 0) begin
        m_st = 0; m_val = 1'b0; m_bad = 0;
      end else if (ones == 1 && idx == 0 && m_pos == N - 1) begin
        m_pos = 0; m_sw = (m_sw + 1) % 100; m_bad = 0;
      end else if (ones == 1 && (idx == m_pos || idx == m_pos + 1)) begin
        m_pos = idx; m_bad = 0;
      end else begin
        m_bad = (m_bad < LIM) ? m_bad + 1 : LIM;
        if (m_bad >= LIM) begin
          m_st = 2; m_err = 1'b1; m_val = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    int exp_bcd;
    exp_bcd = (m_sw / 10) * 16 + (m_sw % 10);
    check_eq("pos_valid", 32'(pos_valid), 32'(m_val));
    if (m_val || m_st == 2) check_eq("pos", 32'(pos), 32'(m_pos));
    check_eq("sweep_bcd", 32'(sweep_bcd), 32'(exp_bcd));
    check_eq("hex0", 32'(hex0), 32'(seg_of(m_sw % 10)));
    check_eq("hex1", 32'(hex1), 32'(seg_of(m_sw / 10)));
    check_eq("err", 32'(err), 32'(m_err));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pos"}, 32'(pos), 32'd0);
    check_eq({tag, "_pos_valid"}, 32'(pos_valid), 32'd0);
    check_eq({tag, "_bcd"}, 32'(sweep_bcd), 32'h00);
    check_eq({tag, "_hex0"}, 32'(hex0), 32'b1000000);
    check_eq({tag, "_hex1"}, 32'(hex1), 32'b1000000);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Drive inputs, take one rising edge, update model, compare; ends at a falling edge.
  task automatic step(input logic [0:N-1] v, input logic cl);
    led_in = v;
    clr_n  = cl;
    @(posedge clk_05);
    model_edge(cl);
    m_samp = v;
    #1;
    check_all();
    @(negedge clk_05);
  endtask

  initial begin
    logic [0:N-1] v;
    int r;
    int a;
    int b;

    // Reset
    rst = 1'b1; clr_n = 1'b1; led_in = '0;
    #2 rst = 1'b0;
    #1 check_reset_vals("reset");
    model_reset();
    @(negedge clk_05);
    rst = 1'b1;

    // One full sweep 0..9,0 then one edge to let the wrap register
    for (int k = 0; k <= N; k++) step(oh(k % N), 1'b1);
    step(oh(1), 1'b1);
    last_idx = 1;
    check_eq("sweep1_bcd", 32'(sweep_bcd), 32'h01);
    check_eq("sweep1_hex0", 32'(hex0), 32'b1111001);
    check_eq("sweep1_hex1", 32'(hex1), 32'b1000000);
    check_eq("sweep1_valid", 32'(pos_valid), 32'd1);

    // 99 more sweeps: 0x99 then rollover to 0x00
    seen99 = 1'b0;
    for (int k = 0; k < 99 * N; k++) begin
      last_idx = (last_idx + 1) % N;
      step(oh(last_idx), 1'b1);
      if (m_sw == 99 && !seen99) begin
        check_eq("bcd_at_99", 32'(sweep_bcd), 32'h99);
        seen99 = 1'b1;
      end
    end
    check_eq("bcd_wrap_100", 32'(sweep_bcd), 32'h00);
    check_eq("hex0_wrap_100", 32'(hex0), 32'b1000000);
    check_eq("hex1_wrap_100", 32'(hex1), 32'b1000000);

    // Two MULTI samples at pos 3, then a good step to 4 must clear the bad count
    step(oh(0), 1'b0);
    step(oh(1), 1'b1); step(oh(2), 1'b1); step(oh(3), 1'b1);
    step(oh(2) | oh(3), 1'b1); step(oh(2) | oh(3), 1'b1);
    step(oh(4), 1'b1); step(oh(4), 1'b1); step(oh(4), 1'b1);
    check_eq("multi_err", 32'(err), 32'd0);
    check_eq("multi_pos", 32'(pos), 32'd4);
    step(oh(2) | oh(3), 1'b1); step(oh(2) | oh(3), 1'b1);
    step(oh(5), 1'b1); step(oh(5), 1'b1);
    check_eq("badcnt_cleared_err", 32'(err), 32'd0);
    check_eq("badcnt_cleared_pos", 32'(pos), 32'd5);

    // Skip to index 5 from pos 3 three times -> FAULT, then clear
    step(oh(0), 1'b0);
    step(oh(1), 1'b1); step(oh(2), 1'b1); step(oh(3), 1'b1);
    step(oh(5), 1'b1); step(oh(5), 1'b1); step(oh(5), 1'b1);
    step(oh(0), 1'b1); step(oh(1), 1'b1);
    check_eq("fault_err", 32'(err), 32'd1);
    check_eq("fault_valid", 32'(pos_valid), 32'd0);
    check_eq("fault_pos", 32'(pos), 32'd3);
    step(oh(0), 1'b0);
    check_eq("clr_err", 32'(err), 32'd0);
    check_eq("clr_bcd", 32'(sweep_bcd), 32'h00);
    check_eq("clr_valid", 32'(pos_valid), 32'd0);

    // Five sweeps, ZERO mid-track holds count, restart adds one more
    for (int k = 1; k <= 5 * N; k++) step(oh(k % N), 1'b1);
    step(oh(1), 1'b1); step(oh(2), 1'b1);
    step('0, 1'b1); step('0, 1'b1);
    check_eq("zero_valid", 32'(pos_valid), 32'd0);
    check_eq("zero_bcd", 32'(sweep_bcd), 32'h05);
    for (int k = 0; k <= N; k++) step(oh(k % N), 1'b1);
    step(oh(1), 1'b1);
    check_eq("restart_bcd", 32'(sweep_bcd), 32'h06);
    check_eq("restart_valid", 32'(pos_valid), 32'd1);

    // Asynchronous reset pulse between edges while tracking
    step(oh(2), 1'b1); step(oh(3), 1'b1);
    rst = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    #1 rst = 1'b1;
    step(oh(0), 1'b1); step(oh(1), 1'b1); step(oh(2), 1'b1);
    last_idx = 2;

    // Randomized LED patterns
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        last_idx = (last_idx + 1) % N; v = oh(last_idx);
      end else if (r < 70) begin
        v = oh(last_idx);
      end else if (r < 78) begin
        last_idx = int'($urandom_range(0, N - 1)); v = oh(last_idx);
      end else if (r < 85) begin
        a = int'($urandom_range(0, N - 1));
        b = (a + 1 + int'($urandom_range(0, N - 2))) % N;
        v = oh(a) | oh(b);
      end else if (r < 90) begin
        v = '0;
      end else if (r < 93) begin
        v = N'($urandom);
      end else begin
        last_idx = 0; v = oh(0);
      end
      step(v, ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sweep_monitor.md
SWEEP_MONITOR -- requirements
Module: sweep_monitor

Interface
REQ-001 SHALL provide parameter N, default 10, the number of LED positions per sweep.
REQ-002 SHALL provide parameter ERR_LIMIT, default 3, the number of consecutive bad samples that forces FAULT.
REQ-003 SHALL provide port clk_05, input, 1 bit: clock, rising edge active.
REQ-004 SHALL provide port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL provide port led_in, input, [0:N-1]: LED bar vector from the rotating-bit stage; led_in[i]=1 means position i.
REQ-006 SHALL provide port clr_n, input, 1 bit: synchronous clear, active-low.
REQ-007 SHALL provide port pos, output, 4 bits: index of the lit position, 0..N-1.
REQ-008 SHALL provide port pos_valid, output, 1 bit: pos holds a valid tracked position.
REQ-009 SHALL provide port sweep_bcd, output, 8 bits: completed sweeps in BCD, tens in [7:4] and ones in [3:0].
REQ-010 SHALL provide ports hex1 and hex0, outputs, 7 bits each: active-low 7-segment encodings of the tens and ones digits.
REQ-011 SHALL provide port err, output, 1 bit: sticky fault flag.

Function
REQ-012 SHALL register led_in into a sample register on every clk_05 rising edge.
REQ-013 SHALL classify each sample as exactly one of three classes:
- ZERO: all bits 0.
- ONEHOT: exactly one bit set; index = position of that bit.
- MULTI: two or more bits set.
REQ-014 SHALL implement states IDLE, TRACK and FAULT, with state, pos, pos_valid, sweep count and err updated on the edge after the sample edge (latency 2 clk_05 edges from led_in).
REQ-015 IDLE: SHALL move to TRACK with pos=0 and pos_valid=1 on ONEHOT index 0; on any other sample SHALL stay in IDLE with pos_valid=0 and leave counters unchanged.
REQ-016 TRACK: SHALL treat ONEHOT with index equal to pos (hold) or pos+1 as a good sample.
- pos updates to the new index.
- The bad-sample counter clears.
REQ-017 TRACK: SHALL treat ONEHOT index 0 while pos=N-1 (wrap) as a good sample and increment the sweep count by 1.
REQ-018 TRACK: SHALL treat MULTI, or ONEHOT of any other index (skip or backward step), as a bad sample.
- pos holds; the bad counter increments.
- On reaching ERR_LIMIT, the block enters FAULT.
REQ-019 TRACK: on ZERO SHALL return to IDLE with pos_valid=0, sweep count held and bad counter cleared.
REQ-020 FAULT: SHALL hold err=1, pos_valid=0 and pos, and SHALL ignore led_in; FAULT exits only via clr_n or rst.
REQ-021 SHALL count sweeps in BCD: ones wrap 9->0 with a carry into tens; 99 wraps to 00 with no flag.
REQ-022 SHALL drive hex0/hex1 combinationally from the registered sweep_bcd using active-low encodings:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-023 clr_n low at an edge SHALL force, overriding all other function:
- state IDLE, pos=0, pos_valid=0
- sweep count 0, bad counter 0, err=0
The sample register keeps loading.
REQ-024 The bad counter SHALL saturate at ERR_LIMIT and SHALL be wide enough to hold ERR_LIMIT.

Reset
REQ-025 rst low SHALL immediately, independent of clk_05, force:
- sample register 0, state IDLE
- pos=0, pos_valid=0, sweep_bcd=0x00, hex0=hex1=1000000, err=0, bad counter 0
REQ-026 While rst is low, outputs SHALL hold reset values; tracking SHALL resume from IDLE on the first edge after release.

Verification
REQ-027 SHALL cover: reset, then led_in one-hot index 0,1,...,9,0, one per edge -> pos follows with 2-edge latency, pos_valid=1, sweep_bcd=0x01, hex0=1111001, hex1=1000000.
REQ-028 SHALL cover: 100 complete sweeps -> sweep_bcd reads 0x99 after the 99th wrap and 0x00 after the 100th; hex0=hex1=1000000.
REQ-029 SHALL cover: in TRACK at pos=3, index 5 for three edges -> err=1 and pos_valid=0 after the third bad sample plus one edge; then clr_n low for one edge -> err=0, state IDLE, sweep_bcd=0x00.
REQ-030 SHALL cover: two bad samples (MULTI, e.g. bits 2 and 3), then index 4 from pos=3 -> err stays 0, pos=4, bad counter cleared.
REQ-031 SHALL cover: ZERO mid-TRACK with sweep_bcd=0x05 -> pos_valid=0 and count held at 0x05; restart at index 0 and complete a sweep -> 0x06.
REQ-032 SHALL cover: rst pulsed low between clk_05 edges during TRACK -> all outputs take reset values before the next edge.
